// File: rtl/multicycle_control.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : multicycle_control                                       |
// | Description : Multicycle MIPS main controller. Steps each instruction  |
// |               through FETCH/DECODE/EXEC/MEM/WB states, drives the      |
// |               datapath enables per state, runs a req/ack memory        |
// |               handshake with a bounded wait and a sticky ERR state.    |
// |               Optional addi support: MULTICYCLE_CONTROL_ADDI_EN.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module multicycle_control #(
  parameter int OP_W     = 6,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            zero_i,
  input  logic            mem_ack_i,
  input  logic            stall_i,
  output logic            mem_req_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            iord_o,
  output logic            ir_write_o,
  output logic            pc_write_o,
  output logic            pc_write_cond_o,
  output logic [1:0]      pc_src_o,
  output logic            alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [1:0]      alu_op_o,
  output logic            reg_write_o,
  output logic            reg_dst_o,
  output logic            mem_to_reg_o,
  output logic            instr_done_o,
  output logic            err_o,
  output logic [3:0]      state_o
);

  localparam logic [3:0] S_RST      = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_WB_R     = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_WB_MEM   = 4'd7;
  localparam logic [3:0] S_MEM_WR   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
  localparam logic [3:0] S_EXEC_I   = 4'd11;
  localparam logic [3:0] S_WB_I     = 4'd12;
`endif
  localparam logic [3:0] S_ERR      = 4'd15;

  localparam logic [CNT_W-1:0] C_MAX_WAIT = CNT_W'(MAX_WAIT);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] w_op;
  logic       w_op_hi_zero;
  logic       w_mem_state;
  logic       w_timeout;
  logic       w_ack_ok;
  logic       w_unused;

  assign w_op         = op_i[5:0];
  // Opcodes wider than 6 bits are legal only with the extra bits at zero.
  assign w_op_hi_zero = ((op_i >> 6) == '0);
  assign w_mem_state  = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                        (state_q == S_MEM_WR);
  assign w_timeout    = (cnt_q == C_MAX_WAIT);
  // An ack during a stall is dropped; the memory has to present it again.
  assign w_ack_ok     = mem_ack_i && !stall_i;
  // The branch decision itself is made in the datapath via pc_write_cond_o.
  assign w_unused     = zero_i;
  assign state_o      = state_q;

  // Next-state selection; stall freezes every transition including timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack_i)      state_d = S_DECODE;
        else if (w_timeout) state_d = S_ERR;
      end
      S_DECODE: begin
        if (!w_op_hi_zero) begin
          state_d = S_ERR;
        end else begin
          case (w_op)
            6'b000000: state_d = S_EXEC_R;
            6'b100011: state_d = S_MEM_ADDR;
            6'b101011: state_d = S_MEM_ADDR;
            6'b000100: state_d = S_BRANCH;
            6'b000010: state_d = S_JUMP;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            6'b001000: state_d = S_EXEC_I;
`endif
            default:   state_d = S_ERR;
          endcase
        end
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      // Bit 3 separates sw (101011) from lw (100011).
      S_MEM_ADDR: state_d = w_op[3] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ack_i)      state_d = S_WB_MEM;
        else if (w_timeout) state_d = S_ERR;
      end
      S_WB_MEM:   state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ack_i)      state_d = S_FETCH;
        else if (w_timeout) state_d = S_ERR;
      end
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_I:     state_d = S_FETCH;
`endif
      S_ERR:      state_d = S_ERR;
      default:    state_d = S_ERR;
    endcase
    if (stall_i) state_d = state_q;
  end

  // Wait counter: cleared on any state change, counts ackless memory cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (!stall_i) begin
      if (state_d != state_q)
        cnt_d = '0;
      else if (w_mem_state && !mem_ack_i)
        cnt_d = cnt_q + 1'b1;
    end
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode of datapath controls; retire pulses are masked by stall.
  always_comb begin
    mem_req_o       = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    iord_o          = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = 2'd0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'd0;
    alu_op_o        = 2'd0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    instr_done_o    = 1'b0;
    err_o           = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        mem_read_o  = 1'b1;
        ir_write_o  = w_ack_ok;
        pc_write_o  = w_ack_ok;
        alu_src_b_o = 2'd1;
      end
      S_DECODE: alu_src_b_o = 2'd3;
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'd2;
      end
      S_WB_R: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = 1'b1;
        instr_done_o = !stall_i;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
      end
      S_MEM_RD: begin
        mem_req_o  = 1'b1;
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = !stall_i;
      end
      S_MEM_WR: begin
        mem_req_o    = 1'b1;
        mem_write_o  = 1'b1;
        iord_o       = 1'b1;
        instr_done_o = w_ack_ok;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = 2'd1;
        pc_write_cond_o = 1'b1;
        pc_src_o        = 2'd1;
        instr_done_o    = !stall_i;
      end
      S_JUMP: begin
        pc_write_o   = 1'b1;
        pc_src_o     = 2'd2;
        instr_done_o = !stall_i;
      end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
      end
      S_WB_I: begin
        reg_write_o  = 1'b1;
        instr_done_o = !stall_i;
      end
`endif
      S_ERR:   err_o = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_multicycle_control                                    |
// | Description : Scoreboard bench for multicycle_control. The driver      |
// |               pushes the expected state per cycle; a negedge monitor   |
// |               pops it and checks state_o and every control output.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_multicycle_control;

  localparam logic [3:0] S_RST = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,
                         S_EXEC_R = 4'd3, S_WB_R = 4'd4, S_MEM_ADDR = 4'd5,
                         S_MEM_RD = 4'd6, S_WB_MEM = 4'd7, S_MEM_WR = 4'd8,
                         S_BRANCH = 4'd9, S_JUMP = 4'd10, S_EXEC_I = 4'd11,
                         S_WB_I = 4'd12, S_ERR = 4'd15;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010,
                         OP_ADDI = 6'b001000, OP_ILL = 6'b111111;

  typedef struct packed {
    logic       req, rd, wr, iord, irw, pcw, pcwc;
    logic [1:0] pcsrc;
    logic       srca;
    logic [1:0] srcb, aluop;
    logic       regw, regdst, m2r, done, err;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    logic       a;
    logic       s;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] op_i = 6'd0;
  logic       zero_i = 1'b0, mem_ack_i = 1'b0, stall_i = 1'b0;
  logic       mem_req_o, mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o;
  logic       pc_write_cond_o, alu_src_a_o, reg_write_o, reg_dst_o, mem_to_reg_o;
  logic       instr_done_o, err_o;
  logic [1:0] pc_src_o, alu_src_b_o, alu_op_o;
  logic [3:0] state_o;

  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;
  exp_t sb[$];
  exp_t cur;
  outs_t obs;

  multicycle_control dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .zero_i(zero_i),
    .mem_ack_i(mem_ack_i), .stall_i(stall_i), .mem_req_o(mem_req_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .iord_o(iord_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
    .pc_write_cond_o(pc_write_cond_o), .pc_src_o(pc_src_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .instr_done_o(instr_done_o), .err_o(err_o),
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    total++;
    if (obs_v !== exp_v) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc_n, obs_v, exp_v);
    end
  endtask

  // Control outputs expected in a given state, taken from the state table.
  function automatic outs_t eo(input logic [3:0] st, input logic a, input logic s);
    outs_t o;
    o = '0;
    case (st)
      S_FETCH:    begin o.req = 1; o.rd = 1; o.irw = a & ~s; o.pcw = a & ~s; o.srcb = 2'd1; end
      S_DECODE:   o.srcb = 2'd3;
      S_EXEC_R:   begin o.srca = 1; o.aluop = 2'd2; end
      S_WB_R:     begin o.regw = 1; o.regdst = 1; o.done = ~s; end
      S_MEM_ADDR: begin o.srca = 1; o.srcb = 2'd2; end
      S_MEM_RD:   begin o.req = 1; o.rd = 1; o.iord = 1; end
      S_WB_MEM:   begin o.regw = 1; o.m2r = 1; o.done = ~s; end
      S_MEM_WR:   begin o.req = 1; o.wr = 1; o.iord = 1; o.done = a & ~s; end
      S_BRANCH:   begin o.srca = 1; o.aluop = 2'd1; o.pcwc = 1; o.pcsrc = 2'd1; o.done = ~s; end
      S_JUMP:     begin o.pcw = 1; o.pcsrc = 2'd2; o.done = ~s; end
      S_EXEC_I:   begin o.srca = 1; o.srcb = 2'd2; end
      S_WB_I:     begin o.regw = 1; o.done = ~s; end
      S_ERR:      o.err = 1;
      default:    ;
    endcase
    return o;
  endfunction

  // Drive one cycle of inputs and record the state expected during it.
  task automatic cyc(input logic r, input logic a, input logic s,
                     input logic [5:0] op, input logic z, input logic [3:0] es);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i = r; mem_ack_i = a; stall_i = s; op_i = op; zero_i = z;
    e.st = es; e.a = a; e.s = s;
    sb.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest scoreboard entry.
  always @(negedge clk_i) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      cyc_n++;
      obs = {mem_req_o, mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o,
             pc_write_cond_o, pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o,
             reg_write_o, reg_dst_o, mem_to_reg_o, instr_done_o, err_o};
      chk("state", 32'(state_o), 32'(cur.st));
      chk("outs", 32'(obs), 32'(eo(cur.st, cur.a, cur.s)));
    end
  end

  initial begin
    // Reset, then R-type with ack one cycle after the request.
    repeat (3) cyc(1, 0, 0, OP_R, 0, S_RST);
    cyc(0, 0, 0, OP_R, 0, S_RST);
    cyc(0, 0, 0, OP_R, 0, S_FETCH);
    cyc(0, 1, 0, OP_R, 0, S_FETCH);
    cyc(0, 0, 0, OP_R, 0, S_DECODE);
    cyc(0, 0, 0, OP_R, 0, S_EXEC_R);
    cyc(0, 0, 0, OP_R, 0, S_WB_R);
    // lw: fetch waits 3 cycles before ack.
    repeat (3) cyc(0, 0, 0, OP_LW, 0, S_FETCH);
    cyc(0, 1, 0, OP_LW, 0, S_FETCH);
    cyc(0, 0, 0, OP_LW, 0, S_DECODE);
    cyc(0, 0, 0, OP_LW, 0, S_MEM_ADDR);
    cyc(0, 0, 0, OP_LW, 0, S_MEM_RD);
    cyc(0, 1, 0, OP_LW, 0, S_MEM_RD);
    cyc(0, 0, 0, OP_LW, 0, S_WB_MEM);
    // sw
    cyc(0, 1, 0, OP_SW, 0, S_FETCH);
    cyc(0, 0, 0, OP_SW, 0, S_DECODE);
    cyc(0, 0, 0, OP_SW, 0, S_MEM_ADDR);
    cyc(0, 0, 0, OP_SW, 0, S_MEM_WR);
    cyc(0, 1, 0, OP_SW, 0, S_MEM_WR);
    // beq with zero, then j
    cyc(0, 1, 0, OP_BEQ, 1, S_FETCH);
    cyc(0, 0, 0, OP_BEQ, 1, S_DECODE);
    cyc(0, 0, 0, OP_BEQ, 1, S_BRANCH);
    cyc(0, 1, 0, OP_J, 0, S_FETCH);
    cyc(0, 0, 0, OP_J, 0, S_DECODE);
    cyc(0, 0, 0, OP_J, 0, S_JUMP);
    // Stalls: ack ignored in FETCH, EXEC_R held 5 cycles, WB_R retire masked.
    cyc(0, 1, 1, OP_R, 0, S_FETCH);
    cyc(0, 1, 0, OP_R, 0, S_FETCH);
    cyc(0, 0, 0, OP_R, 0, S_DECODE);
    repeat (5) cyc(0, 0, 1, OP_R, 0, S_EXEC_R);
    cyc(0, 0, 0, OP_R, 0, S_EXEC_R);
    cyc(0, 0, 1, OP_R, 0, S_WB_R);
    cyc(0, 0, 0, OP_R, 0, S_WB_R);
    // Ack arriving exactly when the counter hits MAX_WAIT wins.
    repeat (15) cyc(0, 0, 0, OP_ADDI, 0, S_FETCH);
    cyc(0, 1, 0, OP_ADDI, 0, S_FETCH);
    cyc(0, 0, 0, OP_ADDI, 0, S_DECODE);
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    cyc(0, 0, 0, OP_ADDI, 0, S_EXEC_I);
    cyc(0, 0, 0, OP_ADDI, 0, S_WB_I);
`else
    cyc(0, 1, 0, OP_ADDI, 0, S_ERR);
    cyc(0, 0, 0, OP_ADDI, 0, S_ERR);
    cyc(1, 0, 0, OP_ADDI, 0, S_RST);
    cyc(0, 0, 0, OP_ADDI, 0, S_RST);
`endif
    // Illegal opcode always lands in sticky ERR.
    cyc(0, 1, 0, OP_ILL, 0, S_FETCH);
    cyc(0, 0, 0, OP_ILL, 0, S_DECODE);
    cyc(0, 1, 0, OP_ILL, 0, S_ERR);
    cyc(0, 0, 0, OP_R, 0, S_ERR);
    cyc(0, 1, 0, OP_R, 0, S_ERR);
    cyc(1, 0, 0, OP_R, 0, S_RST);
    cyc(0, 0, 0, OP_R, 0, S_RST);
    // Timeout: 16 unstalled ackless FETCH cycles, with a stall frozen mid-way.
    repeat (8) cyc(0, 0, 0, OP_R, 0, S_FETCH);
    repeat (4) cyc(0, 0, 1, OP_R, 0, S_FETCH);
    repeat (8) cyc(0, 0, 0, OP_R, 0, S_FETCH);
    cyc(0, 1, 0, OP_R, 0, S_ERR);
    repeat (2) cyc(0, 0, 0, OP_R, 0, S_ERR);
    cyc(1, 0, 0, OP_R, 0, S_RST);
    cyc(0, 0, 0, OP_R, 0, S_RST);
    // Asynchronous reset in the middle of a load.
    cyc(0, 1, 0, OP_LW, 0, S_FETCH);
    cyc(0, 0, 0, OP_LW, 0, S_DECODE);
    cyc(0, 0, 0, OP_LW, 0, S_MEM_ADDR);
    cyc(0, 0, 0, OP_LW, 0, S_MEM_RD);
    cyc(1, 0, 0, OP_LW, 0, S_RST);
    cyc(0, 0, 0, OP_LW, 0, S_RST);
    cyc(0, 0, 0, OP_LW, 0, S_FETCH);
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
